// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared states, request kinds and array bounds for ram_ctrl
package ram_ctrl_pkg;
  localparam int LAST_ADDR = 68;
  typedef enum logic [3:0] {
    IDLE, WR_SETUP, WR_STROBE, WR_HOLD, RD_SETUP, RD_ACT, RD_SAMPLE, RESP, INIT
  } state_t;
  typedef enum logic [1:0] {K_READ, K_WRITE, K_ERR} req_kind_t;
  // Out-of-range addresses are answered without touching the RAM pins.
  function automatic req_kind_t classify(input logic wr, input logic [31:0] addr, input logic [31:0] last);
    return (addr > last) ? K_ERR : (wr ? K_WRITE : K_READ);
  endfunction
endpackage

// File: rtl/ram_init_sweep.sv
// ram_init_sweep: address counter walking 0..N for the zero-fill sweep
module ram_init_sweep #(
  parameter int A = 7,
  parameter int N = 68
) (
  input  logic         clk2,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [A-1:0] o_addr,
  output logic         o_last
);
  logic [A-1:0] r_addr;
  // Counter restarts at 0 on clear, otherwise steps once per swept word.
  always_ff @(posedge clk2 or negedge rst_n)
    if (!rst_n) r_addr <= '0;
    else if (i_clr) r_addr <= '0;
    else if (i_inc) r_addr <= r_addr + 1'b1;
  assign o_addr = r_addr;
  assign o_last = (r_addr == A'(N));
endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl: valid/ready request sequencer driving the ram pins with setup/strobe/hold timing
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int N = LAST_ADDR,
  parameter int M = 8,
  parameter int A = 7
) (
  input  logic         clk2,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [A-1:0] req_addr,
  input  logic [M-1:0] req_wdata,
  output logic         rsp_valid,
  output logic [M-1:0] rsp_rdata,
  output logic         rsp_err,
  input  logic         init_start,
  output logic         init_done,
  output logic         busy,
  output logic         ram_we,
  output logic         ram_act,
  output logic [A-1:0] ram_addr,
  inout  wire  [M-1:0] ram_data
);
  state_t       r_state;
  logic         r_init;
  logic         r_we;
  logic         r_act;
  logic [A-1:0] r_addr;
  logic [M-1:0] r_wdata;
  logic         r_rsp_valid;
  logic         r_rsp_err;
  logic [M-1:0] r_rdata;
  logic         r_init_done;
  logic         r_busy;
  logic [A-1:0] w_sweep_addr;
  logic         w_sweep_last;
  req_kind_t    w_kind;
  assign w_kind    = classify(req_write, 32'(req_addr), 32'(N));
  assign req_ready = rst_n && (r_state == IDLE) && !init_start;
  // Bus is only driven while write-enable is up, which never overlaps a read strobe.
  assign ram_data  = r_we ? r_wdata : 'z;
  ram_init_sweep #(.A(A), .N(N)) u_sweep (
    .clk2   (clk2),
    .rst_n  (rst_n),
    .i_clr  (r_state == IDLE && init_start),
    .i_inc  (r_state == WR_HOLD && r_init && !w_sweep_last),
    .o_addr (w_sweep_addr),
    .o_last (w_sweep_last)
  );
  // Sequencer: every pin and response output is registered on the state transition.
  always_ff @(posedge clk2 or negedge rst_n)
    if (!rst_n) begin
      r_state     <= IDLE;
      r_init      <= 1'b0;
      r_we        <= 1'b0;
      r_act       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rdata     <= '0;
      r_init_done <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_init_done <= 1'b0;
      case (r_state)
        IDLE:
          if (init_start) begin
            r_state <= INIT;
            r_init  <= 1'b1;
            r_we    <= 1'b1;
            r_addr  <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b1;
          end else if (req_valid) begin
            r_busy <= 1'b1;
            if (w_kind == K_ERR) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rdata     <= '0;
            end else if (w_kind == K_WRITE) begin
              r_state <= WR_SETUP;
              r_we    <= 1'b1;
              r_addr  <= req_addr;
              r_wdata <= req_wdata;
            end else begin
              r_state <= RD_SETUP;
              r_addr  <= req_addr;
            end
          end
        INIT, WR_SETUP: begin
          r_state <= WR_STROBE;
          r_act   <= 1'b1;
        end
        WR_STROBE: begin
          r_state <= WR_HOLD;
          r_act   <= 1'b0;
        end
        WR_HOLD:
          if (!r_init) begin
            r_state     <= RESP;
            r_we        <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rdata     <= '0;
          end else if (w_sweep_last) begin
            r_state     <= IDLE;
            r_init      <= 1'b0;
            r_we        <= 1'b0;
            r_init_done <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_state <= INIT;
            r_addr  <= w_sweep_addr + 1'b1;
          end
        RD_SETUP: begin
          r_state <= RD_ACT;
          r_act   <= 1'b1;
        end
        RD_ACT: r_state <= RD_SAMPLE;
        RD_SAMPLE: begin
          r_state     <= RESP;
          r_act       <= 1'b0;
          r_rdata     <= ram_data;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
        end
        RESP: begin
          r_state   <= IDLE;
          r_rsp_err <= 1'b0;
          r_busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_init  <= 1'b0;
          r_we    <= 1'b0;
          r_act   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  assign ram_we    = r_we;
  assign ram_act   = r_act;
  assign ram_addr  = r_addr;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rdata;
  assign init_done = r_init_done;
  assign busy      = r_busy;
endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed bench for ram_ctrl with a behavioural ram on its pins
module tb_ram_ctrl;
  localparam int N = 68;
  localparam int M = 8;
  localparam int A = 7;
  logic         clk2 = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid, req_ready, req_write;
  logic [A-1:0] req_addr;
  logic [M-1:0] req_wdata;
  logic         rsp_valid, rsp_err;
  logic [M-1:0] rsp_rdata;
  logic         init_start, init_done, busy;
  logic         ram_we, ram_act;
  logic [A-1:0] ram_addr;
  wire  [M-1:0] ram_data;
  logic [M-1:0] mem [0:127];
  logic         fill = 1'b1;
  int           n_tests = 0;
  int           n_fail = 0;
  logic         p_we = 1'b0, p_act = 1'b0, p_rst = 1'b0;

  ram_ctrl #(.N(N), .M(M), .A(A)) dut (
    .clk2(clk2), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .init_start(init_start), .init_done(init_done), .busy(busy),
    .ram_we(ram_we), .ram_act(ram_act), .ram_addr(ram_addr), .ram_data(ram_data)
  );

  always #5 clk2 = ~clk2;

  // Behavioural ram: drives the bus on a read strobe, stores on a write strobe.
  assign ram_data = (ram_act && !ram_we) ? mem[ram_addr] : 'z;
  always @(posedge clk2)
    if (fill) for (int i = 0; i < 128; i++) mem[i] <= 8'hFF;
    else if (rst_n && ram_act && ram_we) mem[ram_addr] <= ram_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk2);
    #1;
  endtask

  // Bus rules: no contention during a read strobe, write-enable only moves with strobe low.
  always @(negedge clk2) begin
    if (rst_n && ram_act && !ram_we) chk("bus_rd", ram_data, mem[ram_addr]);
    if (rst_n && p_rst && ram_we !== p_we) chk("we_toggle", p_act | ram_act, 0);
    p_we  = ram_we;
    p_act = ram_act;
    p_rst = rst_n;
  end

  task automatic do_req(input logic wr, input logic [A-1:0] addr, input logic [M-1:0] wd,
                        input int lat, input logic [M-1:0] rd, input logic err);
    int n;
    logic [1:0] exp_pin;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 500) begin
      step();
      n++;
    end
    chk("ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    n = 1;
    while (1) begin
      exp_pin = 2'b00;
      if (!err && n == 1) exp_pin = {wr, 1'b0};
      if (!err && n == 2) exp_pin = {wr, 1'b1};
      if (!err && n == 3) exp_pin = {wr, !wr};
      if (n <= lat) chk("pins", {ram_we, ram_act}, exp_pin);
      if (!err && n <= 3) chk("addr", ram_addr, addr);
      if (!err && wr && n <= 3) chk("wdata", ram_data, wd);
      if (rsp_valid || n >= 20) break;
      step();
      n++;
    end
    chk("latency", n, lat);
    chk("rdata", rsp_rdata, rd);
    chk("err", rsp_err, err);
    step();
    chk("rsp_pulse", rsp_valid, 0);
  endtask

  initial begin
    int n;
    logic bad;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; init_start = 1'b0;
    repeat (3) @(posedge clk2);
    #1;
    fill = 1'b0;
    chk("rst_we", ram_we, 0);
    chk("rst_act", ram_act, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    chk("rst_done", init_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("ready_idle", req_ready, 1);
    // init_start and a read arrive together: sweep wins, read waits
    init_start = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 7'd34; req_wdata = '0;
    #1;
    chk("ready_vs_init", req_ready, 0);
    step();
    init_start = 1'b0;
    n = 1;
    bad = 1'b0;
    while (!init_done && n < 400) begin
      if (rsp_valid || !busy) bad = 1'b1;
      step();
      n++;
    end
    chk("init_len", n, 208);
    chk("init_no_rsp", bad, 0);
    chk("init_busy", busy, 0);
    chk("ready_after", req_ready, 1);
    do_req(1'b0, 7'd34, 8'h00, 4, 8'h00, 1'b0);
    chk("done_pulse", init_done, 0);
    do_req(1'b0, 7'd0, 8'h00, 4, 8'h00, 1'b0);
    do_req(1'b0, 7'd68, 8'h00, 4, 8'h00, 1'b0);
    // write then read back
    do_req(1'b1, 7'd5, 8'hA5, 4, 8'h00, 1'b0);
    do_req(1'b0, 7'd5, 8'h00, 4, 8'hA5, 1'b0);
    // out-of-range addresses
    do_req(1'b0, 7'd69, 8'h00, 1, 8'h00, 1'b1);
    do_req(1'b1, 7'd127, 8'h11, 1, 8'h00, 1'b1);
    // reset during the write strobe leaves old contents
    do_req(1'b1, 7'd10, 8'h3C, 4, 8'h00, 1'b0);
    req_write = 1'b1; req_addr = 7'd10; req_wdata = 8'h77; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk("strobe_pins", {ram_we, ram_act}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("rst_wr_pins", {ram_we, ram_act}, 0);
    chk("rst_wr_busy", busy, 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_wr_ready", req_ready, 1);
    do_req(1'b0, 7'd10, 8'h00, 4, 8'h3C, 1'b0);
    // reset during the sweep: partial fill, not resumed
    do_req(1'b1, 7'd68, 8'h5A, 4, 8'h00, 1'b0);
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    repeat (60) step();
    chk("sweep_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_init_pins", {ram_we, ram_act}, 0);
    chk("rst_init_busy", busy, 0);
    chk("rst_init_done", init_done, 0);
    step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("no_resume", {busy, ram_we, ram_act}, 0);
    do_req(1'b0, 7'd68, 8'h00, 4, 8'h5A, 1'b0);
    do_req(1'b0, 7'd10, 8'h00, 4, 8'h00, 1'b0);
    do_req(1'b0, 7'd5, 8'h00, 4, 8'h00, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
